fetch_decode_pipe: RTL and testbench
====================================

Name: fetch_decode_pipe

Overview:
Parametrised IF+ID front end for the MIPS pipeline. It holds the PC, the IF/ID latch, the register file and the ID/EX latch. It adds behaviour the fixed-width front end lacks: load-use hazard stall, branch flush/bubble insertion, register-file write-through bypass, and valid bits on every latch. It sits between instruction memory and the EX stage; the WB stage drives its write port.

Parameters:
DATA_W, 32, register and datapath width; immediate sign-extended to DATA_W
REG_ADDR_W, 5, register index width; register file depth = 2**REG_ADDR_W
PC_W, 32, program counter width
RESET_PC, 0, PC value after reset
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_src  in  1  branch taken (from EX/MEM); redirect PC and flush
branch_target  in  PC_W  redirect address, used when pc_src=1
imem_addr  out  PC_W  instruction fetch address = PC (combinational)
imem_rdata  in  32  instruction word, combinational read of imem_addr
wb_regwrite  in  1  register-file write enable
wb_rd  in  REG_ADDR_W  write index
wb_data  in  DATA_W  write data
stall  out  1  load-use stall active this cycle
idex_valid  out  1  ID/EX holds a real instruction
idex_wb_ctrl  out  2  {RegWrite, MemtoReg}
idex_mem_ctrl  out  3  {Branch, MemRead, MemWrite}
idex_ex_ctrl  out  4  {RegDst, ALUOp[1:0], ALUSrc}
idex_pc4  out  PC_W  PC+PC_STEP of the instruction
idex_rs_data  out  DATA_W  rs read data
idex_rt_data  out  DATA_W  rt read data
idex_imm  out  DATA_W  sign-extended instr[15:0]
idex_rs, idex_rt, idex_rd  out  REG_ADDR_W each  instr[25:21], [20:16], [15:11], truncated or zero-extended to REG_ADDR_W

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC. IF/ID and ID/EX valid, control fields and data fields = 0. All registers = 0. stall=0.
- PC update, priority order:
  - pc_src: PC <= branch_target
  - stall: hold PC
  - otherwise: PC <= PC+PC_STEP, modulo 2**PC_W
- IF/ID latch:
  - pc_src: flush (valid=0, instr=0)
  - stall: hold
  - otherwise: load imem_rdata and PC+PC_STEP, valid=1
- Decode (combinational from IF/ID), opcode = instr[31:26]:
  - 0x00 R-type: wb=10, mem=000, ex=1_10_0
  - 0x23 lw: wb=11, mem=010, ex=0_00_1
  - 0x2B sw: wb=00, mem=001, ex=0_00_1
  - 0x04 beq: wb=00, mem=100, ex=0_01_0
  - 0x08 addi: wb=10, mem=000, ex=0_00_1
  - any other opcode: all control 0; valid still propagates
- Hazard: stall = ifid_valid & idex_valid & idex_mem_ctrl[1] & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
- ID/EX latch:
  - pc_src or stall: insert bubble (valid=0, all control and data fields 0)
  - otherwise: load decoded fields, valid=ifid_valid; an invalid IF/ID entry loads zero control
- Latency: instruction fetched in cycle N appears on idex_* at the end of cycle N+1 when there is no stall or flush.
- Register file: 2**REG_ADDR_W x DATA_W.
  - Write on rising edge when wb_regwrite=1 and wb_rd!=0; writes to register 0 are ignored and register 0 always reads 0.
  - Write-through: a read index equal to a nonzero wb_rd with wb_regwrite=1 returns wb_data in the same cycle.
- Simultaneous pc_src and stall: pc_src wins; stall is still reported but has no effect.
- Reset mid-operation: in-flight instructions are discarded immediately; first fetch after release is from RESET_PC.

Test Plan:
- Reset then free run with imem holding sequential R-type words: imem_addr 0,4,8,12. idex_valid rises 2 edges after reset release. idex_pc4 = 4 for the first instruction.
- lw $2,0($1) followed by add $3,$2,$4: stall=1 for exactly 1 cycle. PC and IF/ID hold. One bubble (idex_valid=0, ctrl 0) precedes the add. Repeat with lw to $0 -> no stall.
- pc_src=1, branch_target=0x40 while an instruction sits in IF/ID: next imem_addr=0x40. IF/ID flushed. ID/EX bubble. First valid instruction after redirect has idex_pc4=0x44.
- Write-through: wb_regwrite=1, wb_rd=5, wb_data=0xDEADBEEF in the same cycle as decoding rs=5 -> idex_rs_data=0xDEADBEEF. Write to rd=0 with 0x1234 -> later read of $0 = 0.
- Decode/immediate: addi with imm 0xFFF0 -> idex_imm=0xFFFFFFF0, wb=10, ex=0001. Opcode 0x3F -> all control 0 with idex_valid=1.
- Parameter sweep DATA_W=16, REG_ADDR_W=3, RESET_PC=0x100: first imem_addr=0x100. Sign extension and $0 hardwiring still hold.

Source files
------------

// File: rtl/fetch_decode_pipe_if.sv
// Bus bundle between the IF/ID front end, instruction memory, the WB write port and the EX stage.
interface fetch_decode_pipe_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned PC_W       = 32
);
  logic                  pc_src;
  logic [PC_W-1:0]       branch_target;
  logic [PC_W-1:0]       imem_addr;
  logic [31:0]           imem_rdata;
  logic                  wb_regwrite;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_data;
  logic                  stall;
  logic                  idex_valid;
  logic [1:0]            idex_wb_ctrl;
  logic [2:0]            idex_mem_ctrl;
  logic [3:0]            idex_ex_ctrl;
  logic [PC_W-1:0]       idex_pc4;
  logic [DATA_W-1:0]     idex_rs_data;
  logic [DATA_W-1:0]     idex_rt_data;
  logic [DATA_W-1:0]     idex_imm;
  logic [REG_ADDR_W-1:0] idex_rs;
  logic [REG_ADDR_W-1:0] idex_rt;
  logic [REG_ADDR_W-1:0] idex_rd;

  modport master (
    output pc_src, branch_target, imem_rdata, wb_regwrite, wb_rd, wb_data,
    input  imem_addr, stall, idex_valid, idex_wb_ctrl, idex_mem_ctrl, idex_ex_ctrl,
           idex_pc4, idex_rs_data, idex_rt_data, idex_imm, idex_rs, idex_rt, idex_rd
  );

  modport slave (
    input  pc_src, branch_target, imem_rdata, wb_regwrite, wb_rd, wb_data,
    output imem_addr, stall, idex_valid, idex_wb_ctrl, idex_mem_ctrl, idex_ex_ctrl,
           idex_pc4, idex_rs_data, idex_rt_data, idex_imm, idex_rs, idex_rt, idex_rd
  );
endinterface

// File: rtl/fetch_decode_pipe.sv
// MIPS IF+ID front end: PC, IF/ID latch, register file with write-through, ID/EX latch,
// load-use stall and branch flush.
module fetch_decode_pipe #(
  parameter int unsigned     DATA_W     = 32,
  parameter int unsigned     REG_ADDR_W = 5,
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     PC_STEP    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_decode_pipe_if.slave  bus
);
  localparam int unsigned RF_DEPTH = 2 ** REG_ADDR_W;
  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  OP_SW    = 6'h2B;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_ADDI  = 6'h08;

  logic [PC_W-1:0]       pc;
  logic [PC_W-1:0]       pc_plus;
  logic                  ifid_valid;
  logic [31:0]           ifid_instr;
  logic [PC_W-1:0]       ifid_pc4;
  logic [DATA_W-1:0]     rf [RF_DEPTH];

  logic                  idex_valid;
  logic [1:0]            idex_wb;
  logic [2:0]            idex_mem;
  logic [3:0]            idex_ex;
  logic [PC_W-1:0]       idex_pc4;
  logic [DATA_W-1:0]     idex_rs_data;
  logic [DATA_W-1:0]     idex_rt_data;
  logic [DATA_W-1:0]     idex_imm;
  logic [REG_ADDR_W-1:0] idex_rs;
  logic [REG_ADDR_W-1:0] idex_rt;
  logic [REG_ADDR_W-1:0] idex_rd;

  logic [1:0]            dec_wb;
  logic [2:0]            dec_mem;
  logic [3:0]            dec_ex;
  logic [REG_ADDR_W-1:0] dec_rs;
  logic [REG_ADDR_W-1:0] dec_rt;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic [DATA_W-1:0]     dec_imm;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     rt_data;
  logic                  wb_active;
  logic                  stall;

  assign pc_plus = pc + PC_W'(PC_STEP);

  // Field extraction and control decode; an empty IF/ID slot decodes to all-zero control.
  always_comb begin
    dec_wb  = '0;
    dec_mem = '0;
    dec_ex  = '0;
    dec_rs  = REG_ADDR_W'(ifid_instr[25:21]);
    dec_rt  = REG_ADDR_W'(ifid_instr[20:16]);
    dec_rd  = REG_ADDR_W'(ifid_instr[15:11]);
    dec_imm = DATA_W'($signed(ifid_instr[15:0]));
    if (ifid_valid) begin
      case (ifid_instr[31:26])
        OP_RTYPE: begin dec_wb = 2'b10; dec_ex = 4'b1100; end
        OP_LW:    begin dec_wb = 2'b11; dec_mem = 3'b010; dec_ex = 4'b0001; end
        OP_SW:    begin dec_mem = 3'b001; dec_ex = 4'b0001; end
        OP_BEQ:   begin dec_mem = 3'b100; dec_ex = 4'b0010; end
        OP_ADDI:  begin dec_wb = 2'b10; dec_ex = 4'b0001; end
        default:  ;
      endcase
    end
  end

  // Register read with same-cycle write-through from WB; index 0 is never written.
  always_comb begin
    wb_active = bus.wb_regwrite && (bus.wb_rd != '0);
    rs_data   = (wb_active && (bus.wb_rd == dec_rs)) ? bus.wb_data : rf[dec_rs];
    rt_data   = (wb_active && (bus.wb_rd == dec_rt)) ? bus.wb_data : rf[dec_rt];
  end

  assign stall = ifid_valid && idex_valid && idex_mem[1] && (idex_rt != '0) &&
                 ((idex_rt == dec_rs) || (idex_rt == dec_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf <= '{default: '0};
    end else if (wb_active) begin
      rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  // PC and IF/ID: redirect beats stall, stall beats sequential fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (bus.pc_src) begin
      pc         <= bus.branch_target;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
    end else if (!stall) begin
      pc         <= pc_plus;
      ifid_valid <= 1'b1;
      ifid_instr <= bus.imem_rdata;
      ifid_pc4   <= pc_plus;
    end
  end

  // ID/EX: a flush or a load-use stall injects a fully zeroed bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid   <= 1'b0;
      idex_wb      <= '0;
      idex_mem     <= '0;
      idex_ex      <= '0;
      idex_pc4     <= '0;
      idex_rs_data <= '0;
      idex_rt_data <= '0;
      idex_imm     <= '0;
      idex_rs      <= '0;
      idex_rt      <= '0;
      idex_rd      <= '0;
    end else if (bus.pc_src || stall) begin
      idex_valid   <= 1'b0;
      idex_wb      <= '0;
      idex_mem     <= '0;
      idex_ex      <= '0;
      idex_pc4     <= '0;
      idex_rs_data <= '0;
      idex_rt_data <= '0;
      idex_imm     <= '0;
      idex_rs      <= '0;
      idex_rt      <= '0;
      idex_rd      <= '0;
    end else begin
      idex_valid   <= ifid_valid;
      idex_wb      <= dec_wb;
      idex_mem     <= dec_mem;
      idex_ex      <= dec_ex;
      idex_pc4     <= ifid_pc4;
      idex_rs_data <= rs_data;
      idex_rt_data <= rt_data;
      idex_imm     <= dec_imm;
      idex_rs      <= dec_rs;
      idex_rt      <= dec_rt;
      idex_rd      <= dec_rd;
    end
  end

  assign bus.imem_addr     = pc;
  assign bus.stall         = stall;
  assign bus.idex_valid    = idex_valid;
  assign bus.idex_wb_ctrl  = idex_wb;
  assign bus.idex_mem_ctrl = idex_mem;
  assign bus.idex_ex_ctrl  = idex_ex;
  assign bus.idex_pc4      = idex_pc4;
  assign bus.idex_rs_data  = idex_rs_data;
  assign bus.idex_rt_data  = idex_rt_data;
  assign bus.idex_imm      = idex_imm;
  assign bus.idex_rs       = idex_rs;
  assign bus.idex_rt       = idex_rt;
  assign bus.idex_rd       = idex_rd;
endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Bench for fetch_decode_pipe: directed scenarios plus random traffic against a cycle-level reference.
module tb_fetch_decode_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_decode_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .PC_W(32)) bus ();
  fetch_decode_pipe #(.DATA_W(32), .REG_ADDR_W(5), .PC_W(32), .RESET_PC(32'h0), .PC_STEP(4))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  fetch_decode_pipe_if #(.DATA_W(16), .REG_ADDR_W(3), .PC_W(32)) bus2 ();
  fetch_decode_pipe #(.DATA_W(16), .REG_ADDR_W(3), .PC_W(32), .RESET_PC(32'h100), .PC_STEP(4))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [31:0] imem [256];
  assign bus.imem_rdata = imem[bus.imem_addr[9:2]];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        v;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [3:0]  ex;
    logic [31:0] pc4, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
  } idex_t;

  logic [31:0] m_pc;
  logic        m_ifid_v;
  logic [31:0] m_ifid_instr;
  logic [31:0] m_ifid_pc4;
  idex_t       m_idex;
  logic [31:0] m_rf [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control word {wb, mem, ex} for each opcode in the instruction set table.
  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      6'h08:   return 9'b10_000_0001;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (bus.wb_regwrite && bus.wb_rd == idx) return bus.wb_data;
    return m_rf[idx];
  endfunction

  function automatic logic exp_stall();
    logic [4:0] rs, rt;
    rs = m_ifid_instr[25:21];
    rt = m_ifid_instr[20:16];
    return m_ifid_v && m_idex.v && m_idex.mem[1] && m_idex.rt != 5'd0 &&
           (m_idex.rt == rs || m_idex.rt == rt);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ifid_v = 1'b0; m_ifid_instr = 32'h0; m_ifid_pc4 = 32'h0;
    m_idex = '{default: '0};
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_edge();
    idex_t n;
    logic st;
    logic [8:0] c;
    st = exp_stall();
    n = '{default: '0};
    if (!(bus.pc_src || st)) begin
      c     = m_ifid_v ? ctrl_of(m_ifid_instr[31:26]) : 9'b0;
      n.v   = m_ifid_v;
      n.wb  = c[8:7]; n.mem = c[6:4]; n.ex = c[3:0];
      n.pc4 = m_ifid_pc4;
      n.rs  = m_ifid_instr[25:21]; n.rt = m_ifid_instr[20:16]; n.rd = m_ifid_instr[15:11];
      n.rsd = rf_read(n.rs); n.rtd = rf_read(n.rt);
      n.imm = {{16{m_ifid_instr[15]}}, m_ifid_instr[15:0]};
    end
    if (bus.pc_src) begin
      m_ifid_v = 1'b0; m_ifid_instr = 32'h0; m_ifid_pc4 = 32'h0;
      m_pc = bus.branch_target;
    end else if (!st) begin
      m_ifid_v = 1'b1; m_ifid_instr = imem[m_pc[9:2]]; m_ifid_pc4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
    end
    if (bus.wb_regwrite && bus.wb_rd != 5'd0) m_rf[bus.wb_rd] = bus.wb_data;
    m_idex = n;
  endtask

  task automatic check_regs();
    chk("idex_valid", bus.idex_valid,    m_idex.v);
    chk("idex_wb",    bus.idex_wb_ctrl,  m_idex.wb);
    chk("idex_mem",   bus.idex_mem_ctrl, m_idex.mem);
    chk("idex_ex",    bus.idex_ex_ctrl,  m_idex.ex);
    chk("idex_pc4",   bus.idex_pc4,      m_idex.pc4);
    chk("idex_rsd",   bus.idex_rs_data,  m_idex.rsd);
    chk("idex_rtd",   bus.idex_rt_data,  m_idex.rtd);
    chk("idex_imm",   bus.idex_imm,      m_idex.imm);
    chk("idex_rs",    bus.idex_rs,       m_idex.rs);
    chk("idex_rt",    bus.idex_rt,       m_idex.rt);
    chk("idex_rd",    bus.idex_rd,       m_idex.rd);
  endtask

  // One cycle: check fetch/stall, clock the model and DUT, check ID/EX at the falling edge.
  task automatic step();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("stall",     bus.stall,     exp_stall());
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.pc_src = 1'b0; bus.branch_target = 32'h0;
    bus.wb_regwrite = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2B;
      3: op = 6'h04;
      4: op = 6'h08;
      5: op = 6'h3F;
      default: op = 6'($urandom);
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)};
  endfunction

  int  stall_cnt;
  logic found;

  initial begin
    rst_n = 1'b0;
    bus.pc_src = 1'b0; bus.branch_target = 32'h0;
    bus.wb_regwrite = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
    bus2.pc_src = 1'b0; bus2.branch_target = 32'h0;
    bus2.imem_rdata = 32'h210BFFF0;
    bus2.wb_regwrite = 1'b1; bus2.wb_rd = 3'd0; bus2.wb_data = 16'h1234;
    for (int i = 0; i < 256; i++) imem[i] = 32'h00221820;
    model_reset();
    repeat (2) @(negedge clk);

    chk("rst_imem_addr",  bus.imem_addr,    32'h0);
    chk("rst_idex_valid", bus.idex_valid,   1'b0);
    chk("rst_stall",      bus.stall,        1'b0);
    chk("rst_idex_pc4",   bus.idex_pc4,     32'h0);
    chk("rst_idex_wb",    bus.idex_wb_ctrl, 2'b0);
    chk("p2_rst_addr",    bus2.imem_addr,   32'h100);
    rst_n = 1'b1;

    // Free run over sequential R-type words.
    step();
    chk("seq_addr_4",   bus.imem_addr,  32'h4);
    chk("seq_valid_e1", bus.idex_valid, 1'b0);
    chk("p2_addr_104",  bus2.imem_addr, 32'h104);
    step();
    chk("seq_addr_8",   bus.imem_addr,  32'h8);
    chk("seq_valid_e2", bus.idex_valid, 1'b1);
    chk("seq_pc4_4",    bus.idex_pc4,   32'h4);
    chk("p2_valid",     bus2.idex_valid,   1'b1);
    chk("p2_imm",       bus2.idex_imm,     16'hFFF0);
    chk("p2_rs_trunc",  bus2.idex_rs,      3'd0);
    chk("p2_rt_trunc",  bus2.idex_rt,      3'd3);
    chk("p2_rd_trunc",  bus2.idex_rd,      3'd7);
    chk("p2_r0_bypass", bus2.idex_rs_data, 16'h0);
    chk("p2_wb",        bus2.idex_wb_ctrl, 2'b10);
    step();
    chk("seq_addr_12",  bus.imem_addr,  32'hC);

    // lw $2,0($1) then add $3,$2,$4: one stall, then a bubble.
    do_reset();
    imem[0] = 32'h8C220000; imem[1] = 32'h00441820;
    for (int i = 2; i < 256; i++) imem[i] = 32'h00000020;
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.stall) stall_cnt++;
      step();
      if (i == 2) chk("lu_bubble_valid", bus.idex_valid, 1'b0);
    end
    chk("lu_stall_cycles", 32'(stall_cnt), 32'd1);

    // Load into $0 never stalls.
    do_reset();
    imem[0] = 32'h8C200000; imem[1] = 32'h00041820;
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.stall) stall_cnt++;
      step();
    end
    chk("lu_r0_stall_cycles", 32'(stall_cnt), 32'd0);

    // Branch redirect to 0x40 with an instruction sitting in IF/ID.
    do_reset();
    step();
    bus.pc_src = 1'b1; bus.branch_target = 32'h40;
    step();
    bus.pc_src = 1'b0;
    chk("br_addr",       bus.imem_addr,  32'h40);
    chk("br_bubble",     bus.idex_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (bus.idex_valid) begin
        found = 1'b1;
        chk("br_first_pc4", bus.idex_pc4, 32'h44);
      end
    end
    chk("br_valid_seen", found, 1'b1);

    // Write-through on rs=5, and writes to $0 ignored.
    do_reset();
    for (int i = 0; i < 256; i++) imem[i] = 32'h00A03020;
    step();
    bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    step();
    chk("wt_rs_data", bus.idex_rs_data, 32'hDEADBEEF);
    bus.wb_rd = 5'd0; bus.wb_data = 32'h1234;
    step();
    bus.wb_regwrite = 1'b0;
    step();
    chk("wt_r0_read",  bus.idex_rt_data, 32'h0);
    chk("wt_r5_kept",  bus.idex_rs_data, 32'hDEADBEEF);

    // addi with negative immediate, then an unknown opcode.
    do_reset();
    imem[0] = 32'h2000FFF0; imem[1] = 32'hFC000000;
    step(); step();
    chk("addi_imm", bus.idex_imm,     32'hFFFFFFF0);
    chk("addi_wb",  bus.idex_wb_ctrl, 2'b10);
    chk("addi_ex",  bus.idex_ex_ctrl, 4'b0001);
    step();
    chk("unk_valid", bus.idex_valid,    1'b1);
    chk("unk_ctrl",  {bus.idex_wb_ctrl, bus.idex_mem_ctrl, bus.idex_ex_ctrl}, 9'b0);

    // Random traffic against the reference, with a reset dropped in mid-stream.
    do_reset();
    for (int i = 0; i < 256; i++) imem[i] = rand_instr();
    for (int i = 0; i < 400; i++) begin
      bus.pc_src        = ($urandom_range(0, 9) == 0);
      bus.branch_target = $urandom & 32'hFFFF_FFFC;
      bus.wb_regwrite   = 1'($urandom);
      bus.wb_rd         = 5'($urandom_range(0, 4));
      bus.wb_data       = $urandom;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr",  bus.imem_addr,  32'h0);
    chk("mid_rst_valid", bus.idex_valid, 1'b0);
    chk("mid_rst_stall", bus.stall,      1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.pc_src        = ($urandom_range(0, 9) == 0);
      bus.branch_target = $urandom & 32'h0000_03FC;
      bus.wb_regwrite   = 1'($urandom);
      bus.wb_rd         = 5'($urandom_range(0, 4));
      bus.wb_data       = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
